// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin tenure arbiter.
// Holds the FSM state encoding and a one-hot to index decoder.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot word (up to 32 requesters).
    function automatic int unsigned rr_onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] winner_idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   ffs;
    logic [31:0]    sum;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        ffs = rot & (~rot + N'(1));
        sum = rr_onehot_to_idx(32'(ffs)) + 32'(ptr);
        // Explicit modulo so non-power-of-2 N wraps correctly.
        if (sum >= 32'(N)) sum = sum - 32'(N);
        winner_idx = IDW'(sum);
        any        = |req;
    end

endmodule

// File: rtl/rr_tenure_arbiter.sv
// Round-robin arbiter with bounded tenure: the owner is preempted after
// MAX_HOLD cycles when someone else waits; every handover has one idle cycle.
module rr_tenure_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           expire
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [IDW-1:0] LAST     = IDW'(N - 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           expire_q, expire_d;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   own_oh;

    rr_priority_pick #(.N(N), .IDW(IDW)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .any        (pick_any),
        .winner_idx (pick_idx)
    );

    assign own_oh = N'(1) << owner_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        expire_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    hold_d  = HW'(1);
                    ptr_d   = (pick_idx == LAST) ? '0 : pick_idx + IDW'(1);
                end
            end
            GRANT: begin
                // Release wins over preemption when both happen at once.
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (MAX_HOLD != 0 && hold_q == HOLD_MAX &&
                             (req & ~own_oh) != '0) begin
                    state_d  = IDLE;
                    expire_d = 1'b1;
                end else if (MAX_HOLD != 0 && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            expire_q <= expire_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant       = grant_valid ? own_oh : '0;
    assign grant_id    = grant_valid ? owner_q : '0;
    assign expire      = expire_q;

endmodule

// File: tb/tb_rr_tenure_arbiter.sv
// Directed bench for rr_tenure_arbiter: N=4 with MAX_HOLD=4, plus an
// unlimited-tenure instance; hand-computed expectations and live invariants.
module tb_rr_tenure_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] req1 = '0;
    logic [3:0] grant, grant1;
    logic       gv, gv1, expire, expire1;
    logic [1:0] gid, gid1;
    logic [3:0] req_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_tenure_arbiter #(.N(N), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant),
        .grant_valid(gv), .grant_id(gid), .expire(expire)
    );

    rr_tenure_arbiter #(.N(N), .MAX_HOLD(0)) dut_unl (
        .clk(clk), .reset(reset), .req(req1), .grant(grant1),
        .grant_valid(gv1), .grant_id(gid1), .expire(expire1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic ex);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".valid"}, 32'(gv), 32'(g != 4'b0));
        chk({tag, ".id"}, 32'(gid), 32'(id));
        chk({tag, ".expire"}, 32'(expire), 32'(ex));
    endtask

    always @(posedge clk) req_s = req;

    // Structural invariants on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("inv.onehot", 32'($countones(grant) <= 1), 32'(1));
            chk("inv.id", 32'(grant), gv ? 32'(4'b1 << gid) : 32'(0));
            chk("inv.noreq", 32'(grant & ~req_s), 32'(0));
        end
    end

    initial begin
        // 1: reset then idle
        step(); step();
        chk_out("rst", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("idle", 4'b0000, 2'd0, 1'b0);
        end

        // 2: basic grant, release, one idle cycle, next grant
        req = 4'b0101;
        step(); chk_out("t2.g0", 4'b0001, 2'd0, 1'b0);
        step(); chk_out("t2.g0b", 4'b0001, 2'd0, 1'b0);
        req = 4'b0100;
        step(); chk_out("t2.gap", 4'b0000, 2'd0, 1'b0);
        step(); chk_out("t2.g2", 4'b0100, 2'd2, 1'b0);
        req = 4'b0000;
        step(); chk_out("t2.rel", 4'b0000, 2'd0, 1'b0);

        // 3: all requesting, tenure of 4 with expire gap
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk_out("t3.hold", 4'b0001 << (k % 4), 2'(k % 4), 1'b0);
                step();
            end
            chk_out("t3.exp", 4'b0000, 2'd0, 1'b1);
            step();
        end
        chk_out("t3.next", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        step(); chk_out("t3.rel", 4'b0000, 2'd0, 1'b0);

        // 4: lone requester keeps grant; unlimited tenure instance holds owner 0
        req  = 4'b0010;
        req1 = 4'b1111;
        step();
        for (int i = 0; i < 20; i++) begin
            chk_out("t4.lone", 4'b0010, 2'd1, 1'b0);
            chk("t4.unl.grant", 32'(grant1), 32'(4'b0001));
            chk("t4.unl.expire", 32'(expire1), 32'(0));
            step();
        end
        req  = 4'b0000;
        req1 = 4'b0000;
        step(); chk_out("t4.rel", 4'b0000, 2'd0, 1'b0);

        // 5: async reset mid-grant (owner 2)
        req = 4'b0100;
        step(); chk_out("t5.g2", 4'b0100, 2'd2, 1'b0);
        #2 reset = 1'b1;
        #1 chk_out("t5.async", 4'b0000, 2'd0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        req = 4'b1100;
        step(); chk_out("t5.after", 4'b0100, 2'd2, 1'b0);

        // 6: ptr wrap 3 -> 0
        req = 4'b0000;
        step(); chk_out("t6.rel", 4'b0000, 2'd0, 1'b0);
        req = 4'b1001;
        step(); chk_out("t6.g3", 4'b1000, 2'd3, 1'b0);
        req = 4'b0001;
        step(); chk_out("t6.gap", 4'b0000, 2'd0, 1'b0);
        step(); chk_out("t6.g0", 4'b0001, 2'd0, 1'b0);

        // Release coinciding with expiry: counts as release, no expire
        req = 4'b0011;
        step(); step(); step();
        chk_out("t7.hold4", 4'b0001, 2'd0, 1'b0);
        req = 4'b0010;
        step(); chk_out("t7.relexp", 4'b0000, 2'd0, 1'b0);
        step(); chk_out("t7.g1", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
